// File: rtl/tpu_result_drain.sv
// tpu_result_drain: captures the N x N result matrix of the systolic array on
// an output_valid pulse and streams it out one row per beat over valid/ready.
//
// Optional feature macro: TPU_DRAIN_RELU_EN -- when defined, negative elements
// are clamped to zero at capture time. Timing is identical in both builds.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   output_valid      one-cycle result pulse from the TPU
//   result            flat matrix, element (r,c) at [(r*N+c)*ACC_W +: ACC_W]
//   cap_ready         a pulse on output_valid this cycle will be captured
//   out_valid/ready   row beat handshake
//   out_data          one row, column c at [c*ACC_W +: ACC_W]
//   out_row/out_last  row index of the presented beat / high on row N-1
//   busy              a frame is held or draining
//   overrun           sticky: a pulse was dropped; cleared by clr_overrun
//   frame_count       frames fully drained, wraps modulo 2^CNT_W
module tpu_result_drain #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       output_valid,
  input  logic [N*N*ACC_W-1:0]       result,
  output logic                       cap_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*ACC_W-1:0]         out_data,
  output logic [$clog2(N)-1:0]       out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic [CNT_W-1:0]           frame_count
);

  localparam int unsigned ROW_W = N * ACC_W;
  localparam int unsigned MAT_W = N * N * ACC_W;
  localparam int unsigned RW    = $clog2(N);

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [MAT_W-1:0]   buf_q, buf_d;
  logic [RW-1:0]      row_q, row_d;
  logic [ROW_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;

  logic               last_row_c;
  logic               handshake_c;
  logic               cap_ready_c;
  logic               capture_c;
  logic [RW-1:0]      row_nxt_c;
  logic [MAT_W-1:0]   cap_val_c;

  // Capture-time element conditioning (clamp negatives when the feature is on).
  function automatic logic [MAT_W-1:0] cond_f(input logic [MAT_W-1:0] v);
`ifdef TPU_DRAIN_RELU_EN
    logic [MAT_W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < N * N; i++) begin
      if (v[i*ACC_W + ACC_W - 1]) r[i*ACC_W +: ACC_W] = '0;
    end
    return r;
`else
    return v;
`endif
  endfunction

  assign last_row_c  = (row_q == RW'(N - 1));
  assign handshake_c = out_valid_q && out_ready;
  // A new frame may land in the same cycle the last row leaves.
  assign cap_ready_c = (state_q == S_IDLE) ||
                       ((state_q == S_DRAIN) && out_ready && last_row_c);
  assign capture_c   = output_valid && cap_ready_c;
  assign row_nxt_c   = row_q + RW'(1);
  assign cap_val_c   = cond_f(result);

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      row_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      row_q         <= row_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    row_d         = row_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_DRAIN: begin
        if (handshake_c) begin
          if (last_row_c) begin
            frame_count_d = frame_count_q + CNT_W'(1);
            state_d       = S_IDLE;
            row_d         = '0;
            out_data_d    = '0;
          end else begin
            row_d      = row_nxt_c;
            out_data_d = buf_q[32'(row_nxt_c) * ROW_W +: ROW_W];
          end
        end
      end
      default: ;
    endcase

    // Capture overrides the return to IDLE for back-to-back frames.
    if (capture_c) begin
      buf_d      = cap_val_c;
      state_d    = S_DRAIN;
      row_d      = '0;
      out_data_d = cap_val_c[ROW_W-1:0];
    end

    // Set wins over clear.
    if (output_valid && !cap_ready_c) overrun_d = 1'b1;
    else if (clr_overrun)             overrun_d = 1'b0;

    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d == S_DRAIN);
    out_last_d  = (state_d == S_DRAIN) && (row_d == RW'(N - 1));
  end

  assign cap_ready   = cap_ready_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = row_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed bench for tpu_result_drain with a row-beat scoreboard and a small
// reference model of the capture/drain protocol.
module tb_tpu_result_drain;

  localparam int unsigned N     = 8;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ROW_W = N * ACC_W;
  localparam int unsigned MAT_W = N * N * ACC_W;

  typedef struct {
    logic [ROW_W-1:0] data;
    int               row;
    logic             last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               output_valid;
  logic [MAT_W-1:0]   result;
  logic               cap_ready;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_data;
  logic [2:0]         out_row;
  logic               out_last;
  logic               busy;
  logic               overrun;
  logic               clr_overrun;
  logic [CNT_W-1:0]   frame_count;

  tpu_result_drain #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .output_valid(output_valid),
    .result      (result),
    .cap_ready   (cap_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  beat_t  sb[$];
  logic   m_drain  = 1'b0;
  int     m_row    = 0;
  logic   m_ov     = 1'b0;
  int     m_fc     = 0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [ACC_W-1:0] cond_e(input logic [ACC_W-1:0] v);
`ifdef TPU_DRAIN_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Element (r,c) = base + r*16 + c.
  function automatic logic [MAT_W-1:0] make_frame(input int base);
    logic [MAT_W-1:0] f;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(base + r*16 + c);
    return f;
  endfunction

  task automatic push_frame(input logic [MAT_W-1:0] f);
    beat_t b;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++)
        b.data[c*ACC_W +: ACC_W] = cond_e(f[(r*N+c)*ACC_W +: ACC_W]);
      b.row  = r;
      b.last = (r == N - 1);
      sb.push_back(b);
    end
  endtask

  // One clock: check pre-edge handshake against scoreboard, advance model, check post-edge state.
  task automatic step();
    logic  hs, exp_cap;
    beat_t b;
    #1;
    hs      = m_drain && out_ready;
    exp_cap = !m_drain || (hs && m_row == N - 1);
    chk("cap_ready", ROW_W'(cap_ready), ROW_W'(exp_cap));
    if (hs) begin
      if (sb.size() == 0) begin
        n_checks++;
        $error("FAIL sb_underflow observed=beat expected=no_beat");
      end else begin
        b = sb.pop_front();
        chk("beat_data", out_data, b.data);
        chk("beat_row", ROW_W'(out_row), ROW_W'(b.row));
        chk("beat_last", ROW_W'(out_last), ROW_W'(b.last));
      end
      if (m_row == N - 1) begin
        m_fc    = (m_fc + 1) % (1 << CNT_W);
        m_drain = 1'b0;
        m_row   = 0;
      end else begin
        m_row++;
      end
    end
    if (output_valid && exp_cap) begin
      push_frame(result);
      m_drain = 1'b1;
      m_row   = 0;
    end
    if (output_valid && !exp_cap) m_ov = 1'b1;
    else if (clr_overrun)         m_ov = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", ROW_W'(out_valid), ROW_W'(m_drain));
    chk("busy", ROW_W'(busy), ROW_W'(m_drain));
    chk("overrun", ROW_W'(overrun), ROW_W'(m_ov));
    chk("frame_count", ROW_W'(frame_count), ROW_W'(m_fc));
    if (m_drain) begin
      chk("out_row", ROW_W'(out_row), ROW_W'(m_row));
      chk("out_last", ROW_W'(out_last), ROW_W'(m_row == N - 1));
      if (sb.size() > 0) chk("out_data_hold", out_data, sb[0].data);
    end
  endtask

  task automatic capture(input logic [MAT_W-1:0] f);
    result       = f;
    output_valid = 1'b1;
    step();
    output_valid = 1'b0;
  endtask

  task automatic drain_out();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (m_drain && guard < 40) begin
      step();
      guard++;
    end
    if (m_drain) begin
      n_checks++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
  endtask

  task automatic steps_to_row(input int r);
    int guard;
    guard = 0;
    while (m_drain && m_row != r && guard < 20) begin
      step();
      guard++;
    end
  endtask

  initial begin
    logic [MAT_W-1:0] f;
    rst = 1'b1; output_valid = 1'b0; result = '0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", ROW_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_row", ROW_W'(out_row), '0);
    chk("rst_out_last", ROW_W'(out_last), '0);
    chk("rst_busy", ROW_W'(busy), '0);
    chk("rst_overrun", ROW_W'(overrun), '0);
    chk("rst_frame_count", ROW_W'(frame_count), '0);
    rst = 1'b0;

    // Basic drain at full rate.
    capture(make_frame(0));
    drain_out();
    chk("basic_frame_count", ROW_W'(frame_count), ROW_W'(1));
    chk("basic_busy", ROW_W'(busy), '0);

    // Back-pressure held at row 3 for five cycles.
    capture(make_frame(32'h1000));
    steps_to_row(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_row_held", ROW_W'(out_row), ROW_W'(3));
    drain_out();

    // Overrun while draining row 2, then clear.
    capture(make_frame(32'h2000));
    steps_to_row(2);
    capture(make_frame(32'h7777));
    chk("ovr_set", ROW_W'(overrun), ROW_W'(1));
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", ROW_W'(overrun), '0);
    drain_out();

    // Clear and new overrun in the same cycle: set wins.
    capture(make_frame(32'h3000));
    clr_overrun = 1'b1;
    capture(make_frame(32'h7000));
    clr_overrun = 1'b0;
    chk("ovr_set_wins", ROW_W'(overrun), ROW_W'(1));
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    drain_out();

    // Back-to-back: new pulse on the row-7 handshake.
    capture(make_frame(32'h4000));
    steps_to_row(N - 1);
    capture(make_frame(32'h5000));
    chk("b2b_row0", ROW_W'(out_row), '0);
    chk("b2b_valid", ROW_W'(out_valid), ROW_W'(1));
    chk("b2b_overrun", ROW_W'(overrun), '0);
    drain_out();

    // Reset mid-drain at row 4.
    capture(make_frame(32'h6000));
    steps_to_row(4);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ROW_W'(out_valid), '0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_last", ROW_W'(out_last), '0);
    chk("mid_rst_fc", ROW_W'(frame_count), '0);
    sb.delete();
    m_drain = 1'b0; m_row = 0; m_ov = 1'b0; m_fc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    capture(make_frame(32'h0100));
    chk("post_rst_row0", ROW_W'(out_row), '0);
    drain_out();

    // Negative element handling.
    f = make_frame(0);
    f[0 +: ACC_W]     = 32'hFFFF_FFF6;
    f[ACC_W +: ACC_W] = 32'd5;
    capture(f);
`ifdef TPU_DRAIN_RELU_EN
    chk("relu_e00", ROW_W'(out_data[ACC_W-1:0]), '0);
`else
    chk("relu_e00", ROW_W'(out_data[ACC_W-1:0]), ROW_W'(32'hFFFF_FFF6));
`endif
    chk("relu_e01", ROW_W'(out_data[2*ACC_W-1:ACC_W]), ROW_W'(5));
    drain_out();
    chk("sb_empty", ROW_W'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
